// File: rtl/fsb_pkg.sv
`default_nettype none
// ============================================================================
// fsb_pkg : shared state encoding and constants for the front-side-bus bridge
// Rev 1.0 : initial release
// ============================================================================
package fsb_pkg;

   typedef logic [2:0] fsb_state_t;

   localparam fsb_state_t FSB_IDLE   = 3'd0;
   localparam fsb_state_t FSB_SETUP  = 3'd1;
   localparam fsb_state_t FSB_ACCESS = 3'd2;
   localparam fsb_state_t FSB_HOLD   = 3'd3;
   localparam fsb_state_t FSB_RESP   = 3'd4;

   localparam logic [7:0] FSB_RDDATA_TIMEOUT = 8'hFF;
   localparam logic [6:0] FSB_WAIT_RST       = 7'h7F;

   // Chip enable is held for the whole SETUP..HOLD window.
   function automatic logic fsb_is_busy(input fsb_state_t s);
      return (s == FSB_SETUP) || (s == FSB_ACCESS) || (s == FSB_HOLD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fsb_rdy_sync.sv
`default_nettype none
// ============================================================================
// fsb_rdy_sync : two-flop synchroniser for the external ready line
// Rev 1.0 : initial release
// ============================================================================
module fsb_rdy_sync (
   input  logic clki,
   input  logic sys_rst,
   input  logic i_rdy,
   output logic o_rdy
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clki or posedge sys_rst) begin
      if (sys_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_rdy;
         r_sync <= r_meta;
      end
   end

   assign o_rdy = r_sync;

endmodule
`default_nettype wire

// File: rtl/fsb_bridge.sv
`default_nettype none
// ============================================================================
// fsb_bridge : Wishbone 8-bit slave to strobed external front-side bus
// Rev 1.0 : initial release
// ============================================================================
module fsb_bridge
   import fsb_pkg::*;
#(
   parameter int AW        = 16,
   parameter int TO_CYCLES = 255
) (
   input  logic          clki,
   input  logic          sys_rst,
   input  logic          sync_mode,
   input  logic [6:0]    async_waitcycle,
   input  logic [AW-1:0] WB_ADRi,
   input  logic [7:0]    WB_DATi,
   output logic [7:0]    WB_DATo,
   input  logic          WB_WEi,
   input  logic          WB_CYCi,
   input  logic          WB_STBi,
   output logic          WB_ACKo,
   output logic          WB_ERRo,
   output logic [AW-1:0] EXT_ADDR,
   output logic [7:0]    EXT_DQ_o,
   output logic          EXT_DQ_oe,
   input  logic [7:0]    EXT_DQ_i,
   output logic          EXT_CE_n,
   output logic          EXT_OE_n,
   output logic          EXT_WE_n,
   input  logic          EXT_RDY
);

   localparam logic [7:0] c_to_load = 8'(TO_CYCLES);

   fsb_state_t r_state;
   fsb_state_t w_next;

   logic       r_we;
   logic       r_sync;
   logic [6:0] r_wait;
   logic [7:0] r_cnt;
   logic       r_timeout;
   logic       r_abort;
   logic       w_rdy_sync;

   logic       w_accept;
   logic       w_access_done;
   logic       w_timeout_hit;
   logic       w_capture;
   logic [7:0] w_rd_data;
   logic       w_we_eff;
   logic       w_ce_n;
   logic       w_oe_n;
   logic       w_we_n;
   logic       w_dq_oe;
   logic       w_ack;
   logic       w_err;

   fsb_rdy_sync u_rdy_sync (
      .clki    (clki),
      .sys_rst (sys_rst),
      .i_rdy   (EXT_RDY),
      .o_rdy   (w_rdy_sync)
   );

   assign w_accept      = (r_state == FSB_IDLE) && WB_CYCi && WB_STBi;
   assign w_timeout_hit = r_sync && !w_rdy_sync && (r_cnt == 8'd0);
   assign w_access_done = r_sync ? (w_rdy_sync || (r_cnt == 8'd0)) : (r_cnt == 8'd0);

   // State register
   always_ff @(posedge clki or posedge sys_rst) begin
      if (sys_rst) r_state <= FSB_IDLE;
      else         r_state <= w_next;
   end

   // Next-state logic; dropping CYC in SETUP/ACCESS skips RESP entirely
   always_comb begin
      w_next = r_state;
      case (r_state)
         FSB_IDLE:   if (WB_CYCi && WB_STBi) w_next = FSB_SETUP;
         FSB_SETUP:  w_next = WB_CYCi ? FSB_ACCESS : FSB_HOLD;
         FSB_ACCESS: if (!WB_CYCi || w_access_done) w_next = FSB_HOLD;
         FSB_HOLD:   w_next = r_abort ? FSB_IDLE : FSB_RESP;
         FSB_RESP:   w_next = FSB_IDLE;
         default:    w_next = FSB_IDLE;
      endcase
   end

   // Output decode; values are for the cycle after the next edge
   always_comb begin
      w_we_eff  = (r_state == FSB_IDLE) ? WB_WEi : r_we;
      w_ce_n    = !fsb_is_busy(w_next);
      w_oe_n    = !((w_next == FSB_ACCESS) && !r_we);
      w_we_n    = !((w_next == FSB_ACCESS) && r_we);
      w_dq_oe   = w_we_eff && fsb_is_busy(w_next);
      w_ack     = (r_state == FSB_HOLD) && (w_next == FSB_RESP) && !r_timeout;
      w_err     = (r_state == FSB_HOLD) && (w_next == FSB_RESP) && r_timeout;
      w_capture = (r_state == FSB_ACCESS) && (w_next == FSB_HOLD) && WB_CYCi && !r_we;
      w_rd_data = w_timeout_hit ? FSB_RDDATA_TIMEOUT : EXT_DQ_i;
   end

   // Per-transaction latches, wait counter and status flags
   always_ff @(posedge clki or posedge sys_rst) begin
      if (sys_rst) begin
         EXT_ADDR  <= '0;
         EXT_DQ_o  <= 8'h00;
         r_we      <= 1'b0;
         r_sync    <= 1'b0;
         r_wait    <= FSB_WAIT_RST;
         r_cnt     <= 8'd0;
         r_timeout <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         if (w_accept) begin
            EXT_ADDR <= WB_ADRi;
            r_we     <= WB_WEi;
            r_sync   <= sync_mode;
            r_wait   <= async_waitcycle;
            if (WB_WEi) EXT_DQ_o <= WB_DATi;
         end

         if (r_state == FSB_SETUP)
            r_cnt <= r_sync ? c_to_load : {1'b0, r_wait};
         else if ((r_state == FSB_ACCESS) && (r_cnt != 8'd0))
            r_cnt <= r_cnt - 8'd1;

         if ((r_state == FSB_ACCESS) && WB_CYCi && w_timeout_hit)
            r_timeout <= 1'b1;
         else if (w_next == FSB_IDLE)
            r_timeout <= 1'b0;

         if (((r_state == FSB_SETUP) || (r_state == FSB_ACCESS)) && !WB_CYCi)
            r_abort <= 1'b1;
         else if (w_next == FSB_IDLE)
            r_abort <= 1'b0;
      end
   end

   // Registered bus strobes and Wishbone response
   always_ff @(posedge clki or posedge sys_rst) begin
      if (sys_rst) begin
         EXT_CE_n  <= 1'b1;
         EXT_OE_n  <= 1'b1;
         EXT_WE_n  <= 1'b1;
         EXT_DQ_oe <= 1'b0;
         WB_ACKo   <= 1'b0;
         WB_ERRo   <= 1'b0;
         WB_DATo   <= 8'h00;
      end else begin
         EXT_CE_n  <= w_ce_n;
         EXT_OE_n  <= w_oe_n;
         EXT_WE_n  <= w_we_n;
         EXT_DQ_oe <= w_dq_oe;
         WB_ACKo   <= w_ack;
         WB_ERRo   <= w_err;
         if (w_capture) WB_DATo <= w_rd_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fsb_bridge.sv
`default_nettype none
// ============================================================================
// tb_fsb_bridge : randomized self-checking bench with a per-cycle bus model
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fsb_bridge;

   localparam int AW        = 16;
   localparam int TO_CYCLES = 255;

   logic          clki = 1'b0;
   logic          sys_rst;
   logic          sync_mode;
   logic [6:0]    async_waitcycle;
   logic [AW-1:0] WB_ADRi;
   logic [7:0]    WB_DATi;
   logic [7:0]    WB_DATo;
   logic          WB_WEi, WB_CYCi, WB_STBi, WB_ACKo, WB_ERRo;
   logic [AW-1:0] EXT_ADDR;
   logic [7:0]    EXT_DQ_o, EXT_DQ_i;
   logic          EXT_DQ_oe, EXT_CE_n, EXT_OE_n, EXT_WE_n, EXT_RDY;

   fsb_bridge #(.AW(AW), .TO_CYCLES(TO_CYCLES)) dut (
      .clki            (clki),
      .sys_rst         (sys_rst),
      .sync_mode       (sync_mode),
      .async_waitcycle (async_waitcycle),
      .WB_ADRi         (WB_ADRi),
      .WB_DATi         (WB_DATi),
      .WB_DATo         (WB_DATo),
      .WB_WEi          (WB_WEi),
      .WB_CYCi         (WB_CYCi),
      .WB_STBi         (WB_STBi),
      .WB_ACKo         (WB_ACKo),
      .WB_ERRo         (WB_ERRo),
      .EXT_ADDR        (EXT_ADDR),
      .EXT_DQ_o        (EXT_DQ_o),
      .EXT_DQ_oe       (EXT_DQ_oe),
      .EXT_DQ_i        (EXT_DQ_i),
      .EXT_CE_n        (EXT_CE_n),
      .EXT_OE_n        (EXT_OE_n),
      .EXT_WE_n        (EXT_WE_n),
      .EXT_RDY         (EXT_RDY)
   );

   always #5 clki = ~clki;

   int n_checks = 0;
   int n_errors = 0;

   logic [AW-1:0] exp_addr;
   logic [7:0]    exp_dqo;
   logic [7:0]    exp_dato;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ce_n"},  32'(EXT_CE_n),  32'd1);
      chk({tag, "_oe_n"},  32'(EXT_OE_n),  32'd1);
      chk({tag, "_we_n"},  32'(EXT_WE_n),  32'd1);
      chk({tag, "_dq_oe"}, 32'(EXT_DQ_oe), 32'd0);
      chk({tag, "_addr"},  32'(EXT_ADDR),  32'd0);
      chk({tag, "_dq_o"},  32'(EXT_DQ_o),  32'd0);
      chk({tag, "_dato"},  32'(WB_DATo),   32'd0);
      chk({tag, "_ack"},   32'(WB_ACKo),   32'd0);
      chk({tag, "_err"},   32'(WB_ERRo),   32'd0);
   endtask

   // Index i = the half-cycle after clock edge i-1; the request is sampled at edge 0.
   // Model: SETUP at 1, ACCESS 2..L, HOLD L+1, RESP L+2. An abort at index a ends the
   // strobe window at a, HOLD at a+1 and no response.
   task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [7:0] dat,
                          input logic sync, input logic [6:0] w, input int j, input int a,
                          input int dq_fix, input logic [6:0] w_new);
      logic       rdy_a [300];
      logic [7:0] dq_a  [300];
      int   L, e;
      logic to, ab, busy, strobe;
      for (int i = 0; i < 300; i++) begin
         rdy_a[i] = sync ? (i >= j) : 1'($urandom);
         dq_a[i]  = (dq_fix >= 0) ? 8'(dq_fix) : 8'($urandom);
      end
      if (!sync) begin
         L  = int'(w) + 2;
         to = 1'b0;
      end else begin
         // ready reaches the FSM two edges after it is driven
         L  = TO_CYCLES + 2;
         to = 1'b1;
         for (int k = 2; k <= TO_CYCLES + 2; k++)
            if (to && rdy_a[k-2]) begin
               L  = k;
               to = 1'b0;
            end
      end
      ab = (a >= 1) && (a <= L);
      e  = ab ? a : L;

      for (int i = 0; i <= e + 3; i++) begin
         @(negedge clki);
         busy   = (i >= 1) && (i <= e + 1);
         strobe = (i >= 2) && (i <= e);
         chk("ce_n",  32'(EXT_CE_n),  32'(!busy));
         chk("oe_n",  32'(EXT_OE_n),  32'(!(strobe && !we)));
         chk("we_n",  32'(EXT_WE_n),  32'(!(strobe && we)));
         chk("dq_oe", 32'(EXT_DQ_oe), 32'(busy && we));
         chk("ack",   32'(WB_ACKo),   32'(!ab && !to && (i == e + 2)));
         chk("err",   32'(WB_ERRo),   32'(!ab && to && (i == e + 2)));
         if (i >= 1) exp_addr = adr;
         chk("addr",  32'(EXT_ADDR),  32'(exp_addr));
         if (i >= 1 && we) exp_dqo = dat;
         chk("dq_o",  32'(EXT_DQ_o),  32'(exp_dqo));
         if (i == L + 1 && !we && !ab) exp_dato = to ? 8'hFF : dq_a[L];
         chk("dato",  32'(WB_DATo),   32'(exp_dato));

         WB_CYCi = (i <= e + 2) && !(ab && i >= a);
         WB_STBi = (i <= e + 2);
         WB_WEi  = we;
         WB_ADRi = adr;
         WB_DATi = dat;
         if (i == 0) begin
            sync_mode       = sync;
            async_waitcycle = w;
         end
         if (i == 2) begin
            sync_mode       = ~sync;
            async_waitcycle = w_new;
         end
         EXT_RDY  = rdy_a[i];
         EXT_DQ_i = dq_a[i];
      end
   endtask

   logic          r_we_t, r_sync_t;
   logic [AW-1:0] r_adr_t;
   logic [7:0]    r_dat_t;
   logic [6:0]    r_w_t;
   int            r_j_t, r_a_t;

   initial begin
      sys_rst         = 1'b1;
      sync_mode       = 1'b0;
      async_waitcycle = 7'h7F;
      WB_ADRi = '0; WB_DATi = 8'h00; WB_WEi = 1'b0; WB_CYCi = 1'b0; WB_STBi = 1'b0;
      EXT_DQ_i = 8'h00; EXT_RDY = 1'b0;
      exp_addr = '0; exp_dqo = 8'h00; exp_dato = 8'h00;
      repeat (3) @(negedge clki);
      chk_reset_outputs("rst");
      sys_rst = 1'b0;
      @(negedge clki);

      run_txn(1'b0, 16'h0040, 8'h00, 1'b0, 7'd3,   0,    -1, 8'hA5, 7'd9);
      run_txn(1'b1, 16'h1234, 8'h5C, 1'b0, 7'd0,   0,    -1, -1,    7'd0);
      run_txn(1'b0, 16'h2000, 8'h00, 1'b1, 7'd0,   7,    -1, 8'h3C, 7'd0);
      run_txn(1'b0, 16'h2001, 8'h00, 1'b1, 7'd0,   1000, -1, -1,    7'd0);
      run_txn(1'b0, 16'h3000, 8'h00, 1'b0, 7'd2,   0,    -1, -1,    7'd9);
      run_txn(1'b0, 16'h3001, 8'h00, 1'b0, 7'h7F,  0,    -1, -1,    7'd1);
      run_txn(1'b0, 16'h4000, 8'h00, 1'b0, 7'd5,   0,    3,  -1,    7'd5);

      // Reset during SETUP of a write must release the bus at once
      @(negedge clki);
      WB_ADRi = 16'hBEEF; WB_DATi = 8'h77; WB_WEi = 1'b1;
      sync_mode = 1'b0; async_waitcycle = 7'd5;
      WB_CYCi = 1'b1; WB_STBi = 1'b1;
      @(negedge clki);
      chk("setup_ce_n",  32'(EXT_CE_n),  32'd0);
      chk("setup_dq_oe", 32'(EXT_DQ_oe), 32'd1);
      sys_rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clki);
      sys_rst = 1'b0;
      WB_CYCi = 1'b0; WB_STBi = 1'b0;
      exp_addr = '0; exp_dqo = 8'h00; exp_dato = 8'h00;
      run_txn(1'b1, 16'h5555, 8'hC3, 1'b0, 7'd1, 0, -1, -1, 7'd4);
      run_txn(1'b0, 16'h5556, 8'h00, 1'b0, 7'd1, 0, -1, -1, 7'd4);

      for (int t = 0; t < 30; t++) begin
         r_we_t   = 1'($urandom);
         r_adr_t  = AW'($urandom);
         r_dat_t  = 8'($urandom);
         r_sync_t = ($urandom_range(0, 3) == 0);
         r_w_t    = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 10));
         r_j_t    = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 15));
         r_a_t    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
         run_txn(r_we_t, r_adr_t, r_dat_t, r_sync_t, r_w_t, r_j_t, r_a_t, -1,
                 7'($urandom_range(0, 127)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fsb_bridge.md
Name: fsb_bridge

Overview:
- Wishbone 8-bit slave that converts CPU bus cycles into strobed cycles on the external front-side bus (SRAM/flash/parallel peripherals).
- Sits directly downstream of the system controller and consumes its bus-mode outputs: SYNC_MODE selects ready-handshake timing; ASYNC_WAITCYCLE sets the fixed access width.
- Mode and wait count are latched per transaction.

Parameters:
- AW, 16, address width on both Wishbone and external side.
- TO_CYCLES, 255, sync-mode timeout in clki cycles before the bridge gives up waiting for EXT_RDY; range 1..255.

Ports:
- clki  in  1  bridge clock
- sys_rst  in  1  reset, asynchronous, active-high
- sync_mode  in  1  1 = wait for EXT_RDY; 0 = fixed wait count
- async_waitcycle  in  7  extra ACCESS cycles in async mode
- WB_ADRi  in  AW  Wishbone address
- WB_DATi  in  8  write data
- WB_DATo  out  8  registered read data
- WB_WEi  in  1  write enable
- WB_CYCi  in  1  cycle valid
- WB_STBi  in  1  strobe
- WB_ACKo  out  1  one-cycle acknowledge
- WB_ERRo  out  1  one-cycle error; sync timeout only
- EXT_ADDR  out  AW  external address
- EXT_DQ_o  out  8  external write data
- EXT_DQ_oe  out  1  data bus output enable
- EXT_DQ_i  in  8  external read data
- EXT_CE_n  out  1  chip enable, active-low
- EXT_OE_n  out  1  output enable, active-low
- EXT_WE_n  out  1  write enable, active-low
- EXT_RDY  in  1  device ready in sync mode; synchronised through 2 flops

Behaviour:
- Reset (async, sys_rst=1):
  - state IDLE
  - EXT_CE_n, EXT_OE_n, EXT_WE_n = 1
  - EXT_DQ_oe = 0; EXT_ADDR = 0; EXT_DQ_o = 0
  - WB_DATo = 0; WB_ACKo = 0; WB_ERRo = 0
  - counter = 0
- All outputs are registered. Reset mid-transaction releases the external bus immediately; no ACK is issued.
- IDLE:
  - Strobes inactive.
  - On CYC&STB: latch WB_ADRi, WB_DATi, WB_WEi, sync_mode, async_waitcycle, then go to SETUP.
  - Later changes to the mode inputs do not affect the transaction in flight.
- SETUP (1 cycle):
  - EXT_ADDR valid; EXT_CE_n = 0.
  - Write: EXT_DQ_oe = 1 and EXT_DQ_o = latched data.
  - Go to ACCESS; load counter with latched waitcycle (async) or TO_CYCLES (sync).
- ACCESS:
  - Read asserts EXT_OE_n = 0; write asserts EXT_WE_n = 0.
  - Async: counter decrements each cycle. When counter == 0, capture EXT_DQ_i into WB_DATo (read) and go to HOLD. ACCESS lasts waitcycle+1 cycles; waitcycle=0 gives a 1-cycle strobe.
  - Sync: if synchronised EXT_RDY = 1, capture and go to HOLD. Else if counter == 0, set the timeout flag, set WB_DATo = 8'hFF (read), and go to HOLD. Else decrement.
- HOLD (1 cycle):
  - EXT_OE_n and EXT_WE_n = 1; EXT_CE_n stays 0.
  - Write data stays driven (EXT_DQ_oe = 1) through HOLD.
  - Go to RESP.
- RESP (1 cycle):
  - EXT_CE_n = 1; EXT_DQ_oe = 0.
  - WB_ERRo = 1 if timeout flag set, else WB_ACKo = 1. Clear the flag.
  - Go to IDLE.
- Async latency: STB sampled in IDLE at edge 0 → ACK high in cycle W+4. Reset default W=0x7F gives 131.
- Abort: CYC drops during SETUP or ACCESS → go to HOLD, then IDLE. No ACK/ERR; WB_DATo is not updated.
- New request only in IDLE. STB held high while in RESP is not re-sampled until IDLE, giving at least 1 idle cycle between transactions.
- Never both WB_ACKo and WB_ERRo. Never both EXT_OE_n = 0 and EXT_WE_n = 0.
- Read data is captured only at the end of ACCESS.

Decomposition:
- Shared package fsb_pkg holds:
  - state encoding FSB_IDLE/SETUP/ACCESS/HOLD/RESP (3-bit)
  - FSB_RDDATA_TIMEOUT = 8'hFF
  - reset waitcycle default 7'h7F, matching the system controller reset value
- One sub-module, fsb_rdy_sync: 2-flop synchroniser for EXT_RDY with async clear on sys_rst.
- The counter stays inline.

Test Plan:
- Async read, waitcycle=3, EXT_DQ_i=8'hA5 → EXT_OE_n low exactly 4 cycles; ACK in cycle 7 after STB; WB_DATo=8'hA5; CE_n low 6 cycles.
- Async write, waitcycle=0, addr 0x1234, data 0x5C → EXT_WE_n low 1 cycle; EXT_DQ_oe high SETUP..HOLD (3 cycles) with EXT_DQ_o=0x5C; ACK in cycle 4.
- Sync read, EXT_RDY raised 5 cycles into ACCESS, data 0x3C → capture after 2-flop sync delay; ACK; WB_DATo=0x3C; WB_ERRo never high.
- Sync read, EXT_RDY held 0, TO_CYCLES=255 → ERR pulse (no ACK) after 256 ACCESS cycles; WB_DATo=0xFF; strobes released.
- Change sync_mode/async_waitcycle from 2 to 9 mid-ACCESS → transaction still completes with the latched mode and waitcycle=2.
- CYC dropped in ACCESS, then sys_rst pulsed during the next transaction's SETUP → no ACK; all strobes high and EXT_DQ_oe=0 immediately on reset; the next request after reset completes normally.
